mem_interleaved_pipe: RTL and testbench
=======================================

# mem_interleaved_pipe

Parametrised interleaved memory with 2^B banks, each with a fixed occupancy of T cycles, behind a valid/ready request port and a fixed-latency read-response port. The low B address bits select the bank. Consecutive addresses go to different banks and overlap; back-to-back accesses to one bank stall on bank conflict. It is the successor to the two-module, zero-latency interleaved memory and serves as the main-memory model for the pipelined processor datapath.

## Interface
Parameters:
- M, 8, cell width in bits
- K, 11, address width; total capacity 2^K cells
- B, 1, log2 of bank count; 1 ≤ B < K
- T, 2, bank cycle time and read latency in cycles; T ≥ 1
- S, 16, width of the stall counter

Ports:
- clock  input  1  single clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  request can be accepted this cycle
- WE  input  1  1 = write, 0 = read; qualified by req_valid
- A  input  K  cell address
- WD  input  M  write data
- rsp_valid  output  1  RD holds read data this cycle
- RD  output  M  read data
- bank_busy  output  2^B  per-bank occupancy flags
- stall_count  output  S  saturating count of conflict-stall cycles

## Operation
- Bank index is A[B-1:0]; row within the bank is A[K-1:B]. Each bank is an array of 2^(K-B) cells of M bits.
- Each bank has a counter cnt_i of width ceil(log2(T)) + 1. bank_busy[i] = (cnt_i != 0).
- req_ready = ~bank_busy[A[B-1:0]]. This is combinational from A and state. It does not depend on req_valid.
- A request is accepted when req_valid & req_ready is high at a rising edge. At most one request is accepted per cycle.
- On accept:
  - The selected bank's cnt is loaded with T-1.
  - All other nonzero counters decrement by 1.
- No accept: every nonzero counter decrements by 1.
- Accepted write: WD is stored to bank[A[B-1:0]][A[K-1:B]] at the accept edge. No response is generated.
- Accepted read: the cell contents before that edge are captured into stage 0 of a T-deep response shift register, together with a valid bit.
  - The shift register advances every cycle.
  - rsp_valid and RD are driven by the last stage.
  - When no response is present, RD holds 0.
- Responses return in issue order, because all reads have the same latency.
- Read-after-write to the same address returns the new data, because the second access cannot be accepted before the bank is free.
- Stall counting: stall_count increments at each edge where req_valid & ~req_ready. It saturates at 2^S-1.
- Reset (reset_n low), applied immediately and asynchronously:
  - cnt_i = 0 for all banks, so bank_busy = 0 and req_ready = 1.
  - Response pipeline cleared; rsp_valid = 0, RD = 0.
  - stall_count = 0.
  - Array contents are not reset.
  - Reads in flight are discarded. Writes accepted before reset assertion persist.
- Requests with req_valid low are ignored: no state change except counter decrements.

## Timing
- Accept at edge e0 (cycle c0):
  - The bank is busy during cycles c0+1 … c0+T-1 and accepts again in cycle c0+T.
  - For a read, rsp_valid = 1 and RD is valid during cycle c0+T only.
- T = 1: no bank occupancy; the same bank accepts every cycle; read data arrives one cycle after accept.
- Peak throughput: one access per cycle when the bank index rotates with period ≥ T and 2^B ≥ T.
- A stalled request must hold A, WE and WD stable until accepted.
- Release of reset_n must be synchronous to clock. The first request can be accepted at the first edge after release.

## Test plan
Default bench configuration: M=8, K=6, B=2, T=3.
- Reset: assert reset_n=0 mid-read (accept read at addr 5, reset in cycle c0+1) → rsp_valid stays 0 through c0+5; bank_busy=0, stall_count=0, req_ready=1 immediately.
- Sequential streaming: write 0x10+a to addresses 0..15 in 16 consecutive cycles → no stalls (req_ready always 1), stall_count=0. Then read 0..15 back-to-back → rsp_valid high cycles c0+3 … c0+18, RD = 0x10..0x1F in order.
- Bank conflict: read addr 4 then addr 8 (both bank 0) with req_valid held → second accepted 3 cycles after first, stall_count=2, bank_busy[0] high for 2 cycles after each accept.
- Read-after-write: write 0xA5 to addr 7, then read addr 7 → read accepted 3 cycles later; RD=0xA5 with rsp_valid 3 cycles after that.
- Mixed interleave: write addr 1, read addr 2, read addr 1 (bank 1 conflict) → read of 2 returns old data at c+4; read of 1 is accepted at c+3, returns the new value at c+6, stall_count=1.
- T=1, B=1 build: read addr 0 every cycle for 4 cycles → no stalls, rsp_valid high for 4 consecutive cycles starting one cycle after the first accept.

Source files
------------

// File: rtl/mem_interleaved_pipe.sv
// Interleaved main memory: 2^B banks selected by the low address bits, each busy for T cycles
// after an access, with a T-deep in-order read-response pipeline and a conflict-stall counter.
module mem_interleaved_pipe #(
    parameter int M = 8,
    parameter int K = 11,
    parameter int B = 1,
    parameter int T = 2,
    parameter int S = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               WE,
    input  logic [K-1:0]       A,
    input  logic [M-1:0]       WD,
    output logic               rsp_valid,
    output logic [M-1:0]       RD,
    output logic [(1<<B)-1:0]  bank_busy,
    output logic [S-1:0]       stall_count
);

    localparam int NB   = 1 << B;
    localparam int ROWS = 1 << (K - B);
    localparam int CW   = $clog2(T) + 1;

    logic [B-1:0]   bank_sel;
    logic [K-B-1:0] row_sel;
    logic           accept;
    logic           rd_accept;
    logic           wr_accept;

    logic [CW-1:0]  cnt_q [NB];
    logic [CW-1:0]  cnt_d [NB];
    logic [T-1:0]   vld_q;
    logic [T-1:0]   vld_d;
    logic [M-1:0]   dat_q [T];
    logic [M-1:0]   dat_d [T];
    logic [S-1:0]   stall_q;
    logic [S-1:0]   stall_d;

    logic [M-1:0]   mem_q [NB][ROWS];

    assign bank_sel = A[B-1:0];
    assign row_sel  = A[K-1:B];

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            bank_busy[i] = (cnt_q[i] != '0);
        end
    end

    // Handshake: a request transfers on a rising edge where req_valid and req_ready are both
    // high; req_ready depends only on A and bank state, and a stalled request holds A/WE/WD.
    assign req_ready = ~bank_busy[bank_sel];
    assign accept    = req_valid & req_ready;
    assign rd_accept = accept & ~WE;
    assign wr_accept = accept & WE;

    always_comb begin
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = cnt_q[i];
            if (accept && (bank_sel == B'(i))) begin
                cnt_d[i] = CW'(T - 1);
            end else if (cnt_q[i] != '0) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    // Data of empty stages is forced to zero so RD reads 0 whenever no response is present.
    always_comb begin
        vld_d    = '0;
        vld_d[0] = rd_accept;
        dat_d[0] = rd_accept ? mem_q[bank_sel][row_sel] : '0;
        for (int j = 1; j < T; j++) begin
            vld_d[j] = vld_q[j-1];
            dat_d[j] = dat_q[j-1];
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (req_valid && !req_ready && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
            for (int j = 0; j < T; j++) begin
                dat_q[j] <= '0;
            end
            vld_q   <= '0;
            stall_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
            stall_q <= stall_d;
        end
    end

    // Array contents survive reset; the reset_n gate only blocks writes while reset is held.
    always_ff @(posedge clock) begin
        if (wr_accept && reset_n) begin
            mem_q[bank_sel][row_sel] <= WD;
        end
    end

    assign rsp_valid   = vld_q[T-1];
    assign RD          = dat_q[T-1];
    assign stall_count = stall_q;

    generate
        for (genvar g = 0; g < NB; g++) begin : g_cnt_chk
            a_cnt_bound: assert property (@(posedge clock) disable iff (!reset_n)
                cnt_q[g] <= CW'(T - 1));
        end
    endgenerate

    a_stall_hold: assert property (@(posedge clock) disable iff (!reset_n)
        (req_valid && !req_ready) |=> (!req_valid || ($stable(A) && $stable(WE) && $stable(WD))));

endmodule

// File: tb/tb_mem_interleaved_pipe.sv
// Self-checking bench: directed table, reset/T=1 sequences and random traffic against a
// cycle-timestamp model of bank availability and read-response delivery.
module tb_mem_interleaved_pipe;

    localparam int T = 3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, we;
    logic [5:0]  a;
    logic [7:0]  wd, rd;
    logic        rsp_valid;
    logic [3:0]  bank_busy;
    logic [15:0] stall_count;

    logic        rv1, rdy1, we1, rspv1;
    logic [5:0]  a1;
    logic [7:0]  wd1, rd1;
    logic [1:0]  busy1;
    logic [15:0] stall1;

    mem_interleaved_pipe #(.M(8), .K(6), .B(2), .T(T), .S(16)) u_dut (
        .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .WE(we), .A(a), .WD(wd), .rsp_valid(rsp_valid), .RD(rd),
        .bank_busy(bank_busy), .stall_count(stall_count)
    );

    mem_interleaved_pipe #(.M(8), .K(6), .B(1), .T(1), .S(16)) u_dut1 (
        .clock(clock), .reset_n(reset_n), .req_valid(rv1), .req_ready(rdy1),
        .WE(we1), .A(a1), .WD(wd1), .rsp_valid(rspv1), .RD(rd1),
        .bank_busy(busy1), .stall_count(stall1)
    );

    // clock / reset
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: memory image, cycle at which each bank frees up, stall total
    logic [7:0]  ref_mem [64];
    int          free_at [4];
    int          ref_stall = 0;
    int          cyc = 0;
    int          due_q[$];
    logic [7:0]  exp_q[$];
    logic        mon_en = 1'b0;

    // scoreboard: each cycle either the oldest expected read is due, or the port is idle
    always @(negedge clock) begin
        if (mon_en) begin
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                check("rsp_valid", 32'(rsp_valid), 32'd1);
                check("rd_data", 32'(rd), 32'(exp_q[0]));
                void'(due_q.pop_front());
                void'(exp_q.pop_front());
            end else begin
                check("rsp_idle_valid", 32'(rsp_valid), 32'd0);
                check("rsp_idle_rd", 32'(rd), 32'd0);
            end
        end
    end

    // driver: one cycle of request, with model update at the edge
    task automatic step(input logic v, input logic w, input logic [5:0] addr, input logic [7:0] d,
                        output logic got_ready, output logic [15:0] got_stall);
        int   b;
        logic rdy;
        @(negedge clock);
        req_valid = v; we = w; a = addr; wd = d;
        #1;
        b   = int'(addr[1:0]);
        rdy = !(cyc < free_at[b]);
        got_ready = req_ready;
        got_stall = stall_count;
        check("req_ready", 32'(req_ready), 32'(rdy));
        for (int i = 0; i < 4; i++) begin
            check("bank_busy", 32'(bank_busy[i]), 32'(cyc < free_at[i]));
        end
        check("stall_count", 32'(stall_count), 32'(ref_stall));
        @(posedge clock);
        if (v && rdy) begin
            free_at[b] = cyc + T;
            if (w) begin
                ref_mem[addr] = d;
            end else begin
                due_q.push_back(cyc + T);
                exp_q.push_back(ref_mem[addr]);
            end
        end else if (v) begin
            ref_stall++;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        logic        r;
        logic [15:0] s;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'd0, 8'd0, r, s);
    endtask

    typedef struct {
        logic        v;
        logic        w;
        logic [5:0]  a;
        logic [7:0]  d;
        logic        exp_ready;
        logic [15:0] exp_stall;
    } vec_t;

    vec_t vecs [19];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        r, pend;
        logic [15:0] s;
        logic        v, w;
        logic [5:0]  ad;
        logic [7:0]  d;

        // conflict, read-after-write and mixed-interleave sequences (stall absolute after reset)
        vecs[0]  = '{1'b1, 1'b0, 6'd4,  8'h00, 1'b1, 16'd0};
        vecs[1]  = '{1'b1, 1'b0, 6'd8,  8'h00, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 1'b0, 6'd8,  8'h00, 1'b0, 16'd1};
        vecs[3]  = '{1'b1, 1'b0, 6'd8,  8'h00, 1'b1, 16'd2};
        vecs[4]  = '{1'b0, 1'b0, 6'd0,  8'h00, 1'b0, 16'd2};
        vecs[5]  = '{1'b0, 1'b0, 6'd0,  8'h00, 1'b0, 16'd2};
        vecs[6]  = '{1'b0, 1'b0, 6'd0,  8'h00, 1'b1, 16'd2};
        vecs[7]  = '{1'b1, 1'b1, 6'd7,  8'hA5, 1'b1, 16'd2};
        vecs[8]  = '{1'b1, 1'b0, 6'd7,  8'h00, 1'b0, 16'd2};
        vecs[9]  = '{1'b1, 1'b0, 6'd7,  8'h00, 1'b0, 16'd3};
        vecs[10] = '{1'b1, 1'b0, 6'd7,  8'h00, 1'b1, 16'd4};
        vecs[11] = '{1'b1, 1'b1, 6'd1,  8'h5C, 1'b1, 16'd4};
        vecs[12] = '{1'b1, 1'b0, 6'd2,  8'h00, 1'b1, 16'd4};
        vecs[13] = '{1'b1, 1'b0, 6'd1,  8'h00, 1'b0, 16'd4};
        vecs[14] = '{1'b1, 1'b0, 6'd1,  8'h00, 1'b1, 16'd5};
        vecs[15] = '{1'b0, 1'b0, 6'd0,  8'h00, 1'b1, 16'd5};
        vecs[16] = '{1'b0, 1'b0, 6'd0,  8'h00, 1'b1, 16'd5};
        vecs[17] = '{1'b0, 1'b0, 6'd0,  8'h00, 1'b1, 16'd5};
        vecs[18] = '{1'b0, 1'b0, 6'd0,  8'h00, 1'b1, 16'd5};

        for (int i = 0; i < 4; i++) free_at[i] = 0;
        reset_n = 1'b0;
        req_valid = 1'b0; we = 1'b0; a = '0; wd = '0;
        rv1 = 1'b0; we1 = 1'b0; a1 = '0; wd1 = '0;
        #1;
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_busy", 32'(bank_busy), 32'd0);
        check("reset_stall", 32'(stall_count), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rd", 32'(rd), 32'd0);
        #21 reset_n = 1'b1;
        mon_en = 1'b1;

        // preload every cell, then sequential streaming writes and reads
        for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 6'(i), 8'(i * 3 + 1), r, s);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b1, 6'(i), 8'(8'h10 + i), r, s);
            check("stream_wr_ready", 32'(r), 32'd1);
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 6'(i), 8'h00, r, s);
            check("stream_rd_ready", 32'(r), 32'd1);
        end
        idle(4);
        check("stream_queue_drained", 32'(due_q.size()), 32'd0);

        // asynchronous reset in the cycle after a read is accepted
        step(1'b1, 1'b0, 6'd5, 8'h00, r, s);
        @(negedge clock);
        reset_n = 1'b0; req_valid = 1'b0;
        due_q.delete(); exp_q.delete();
        ref_stall = 0;
        for (int i = 0; i < 4; i++) free_at[i] = 0;
        #1;
        check("async_rst_ready", 32'(req_ready), 32'd1);
        check("async_rst_busy", 32'(bank_busy), 32'd0);
        check("async_rst_stall", 32'(stall_count), 32'd0);
        check("async_rst_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clock);
        cyc++;
        idle(1);
        #2 reset_n = 1'b1;
        idle(3);

        // table-driven directed vectors
        for (int i = 0; i < 19; i++) begin
            step(vecs[i].v, vecs[i].w, vecs[i].a, vecs[i].d, r, s);
            check($sformatf("vec%0d_ready", i), 32'(r), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d_stall", i), 32'(s), 32'(vecs[i].exp_stall));
        end

        // random traffic; a stalled request is held until accepted
        pend = 1'b0;
        v = 1'b0; w = 1'b0; ad = '0; d = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend) begin
                v  = ($urandom_range(0, 9) < 7);
                w  = 1'($urandom_range(0, 1));
                ad = 6'($urandom_range(0, 63));
                d  = 8'($urandom_range(0, 255));
            end
            step(v, w, ad, d, r, s);
            pend = v && !r;
        end
        idle(5);
        check("random_queue_drained", 32'(due_q.size()), 32'd0);
        mon_en = 1'b0;

        // T=1, B=1 instance: write addr 0, then read it four cycles in a row
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            rv1 = (k <= 4); we1 = (k == 0); a1 = 6'd0; wd1 = 8'h3C;
            #1;
            check("t1_ready", 32'(rdy1), 32'd1);
            check("t1_rsp_valid", 32'(rspv1), 32'(k >= 2 && k <= 5));
            check("t1_rd", 32'(rd1), (k >= 2 && k <= 5) ? 32'h3C : 32'd0);
            check("t1_stall", 32'(stall1), 32'd0);
            check("t1_busy", 32'(busy1), 32'd0);
        end
        @(negedge clock);
        rv1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
